// File: rtl/ex_result_pipe.sv
// ex_result_pipe: consumer end of the Execute result/forwarding interface.
//
// Captures each Execute result into a DEPTH-stage shift pipeline, drives the
// register-file write port from the oldest stage, and produces the 2-bit
// operand forwarding selects plus forwarded data for Execute's operand muxes.
//
// Parameters:
//   DEPTH   in-flight result stages, legal 1..3 (limited by the 2-bit select)
//   DATA_W  result/operand width
//   REG_W   register address width
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   ex_valid, ex_wr_en    Execute instruction valid / writes a register
//   ex_result, ex_dest    Execute result and destination register
//   stall, flush          freeze pipeline / drop current capture
//   ra_addr, rb_addr      source registers of the instruction entering Execute
//   fwd_sel_a/b           forwarding select (00 none, 01..11 stage 1..3)
//   fwd_data_a/b          forwarded data (0 when select is 00)
//   wb_en, wb_addr, wb_data  register-file write port
//   fwd_count             forwarding event counter
//
// Build option: define FWD_COUNT_EN to build the forwarding event counter;
// otherwise fwd_count is tied to 0.

module ex_result_pipe #(
    parameter int unsigned DEPTH  = 3,
    parameter int unsigned DATA_W = 128,
    parameter int unsigned REG_W  = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic              ex_wr_en,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [REG_W-1:0]  ex_dest,
    input  logic              stall,
    input  logic              flush,
    input  logic [REG_W-1:0]  ra_addr,
    input  logic [REG_W-1:0]  rb_addr,
    output logic [1:0]        fwd_sel_a,
    output logic [1:0]        fwd_sel_b,
    output logic [DATA_W-1:0] fwd_data_a,
    output logic [DATA_W-1:0] fwd_data_b,
    output logic              wb_en,
    output logic [REG_W-1:0]  wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic [31:0]       fwd_count
);

    // Index 0 is stage 1 (youngest), index DEPTH-1 is the writeback stage.
    logic [DEPTH-1:0]  v_q;
    logic [REG_W-1:0]  dest_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                dest_q[s] <= '0;
                data_q[s] <= '0;
            end
        end else if (!stall) begin
            // Dest/data are captured even for bubbles; only v gates their use.
            v_q[0]    <= ex_valid & ex_wr_en & ~flush;
            dest_q[0] <= ex_dest;
            data_q[0] <= ex_result;
            for (int s = 1; s < DEPTH; s++) begin
                v_q[s]    <= v_q[s-1];
                dest_q[s] <= dest_q[s-1];
                data_q[s] <= data_q[s-1];
            end
        end
    end

    // Suppress the write while frozen so a held entry is written exactly once.
    assign wb_en   = v_q[DEPTH-1] & ~stall;
    assign wb_addr = dest_q[DEPTH-1];
    assign wb_data = data_q[DEPTH-1];

    // Scan oldest to youngest so the youngest matching stage is the last
    // assignment and wins. The writeback stage stays forwardable because the
    // register file is not write-first.
    always_comb begin
        fwd_sel_a  = 2'b00;
        fwd_sel_b  = 2'b00;
        fwd_data_a = '0;
        fwd_data_b = '0;
        for (int s = DEPTH - 1; s >= 0; s--) begin
            if (v_q[s] && (dest_q[s] == ra_addr)) begin
                fwd_sel_a  = 2'(s + 1);
                fwd_data_a = data_q[s];
            end
            if (v_q[s] && (dest_q[s] == rb_addr)) begin
                fwd_sel_b  = 2'(s + 1);
                fwd_data_b = data_q[s];
            end
        end
    end

`ifdef FWD_COUNT_EN
    logic [31:0] fwd_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fwd_count_q <= '0;
        end else if (!stall && ((fwd_sel_a != 2'b00) || (fwd_sel_b != 2'b00))) begin
            fwd_count_q <= fwd_count_q + 32'd1;
        end
    end

    assign fwd_count = fwd_count_q;
`else
    assign fwd_count = '0;
`endif

endmodule

// File: tb/tb_ex_result_pipe.sv
// Self-checking bench for ex_result_pipe with a queue-based reference model.
module tb_ex_result_pipe;

    localparam int unsigned DEPTH  = 3;
    localparam int unsigned DATA_W = 128;
    localparam int unsigned REG_W  = 7;
`ifdef FWD_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              ex_valid;
    logic              ex_wr_en;
    logic [DATA_W-1:0] ex_result;
    logic [REG_W-1:0]  ex_dest;
    logic              stall;
    logic              flush;
    logic [REG_W-1:0]  ra_addr;
    logic [REG_W-1:0]  rb_addr;
    logic [1:0]        fwd_sel_a;
    logic [1:0]        fwd_sel_b;
    logic [DATA_W-1:0] fwd_data_a;
    logic [DATA_W-1:0] fwd_data_b;
    logic              wb_en;
    logic [REG_W-1:0]  wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [31:0]       fwd_count;

    int checks = 0;
    int errors = 0;

    ex_result_pipe #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ex_valid   (ex_valid),
        .ex_wr_en   (ex_wr_en),
        .ex_result  (ex_result),
        .ex_dest    (ex_dest),
        .stall      (stall),
        .flush      (flush),
        .ra_addr    (ra_addr),
        .rb_addr    (rb_addr),
        .fwd_sel_a  (fwd_sel_a),
        .fwd_sel_b  (fwd_sel_b),
        .fwd_data_a (fwd_data_a),
        .fwd_data_b (fwd_data_b),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .fwd_count  (fwd_count)
    );

    always #5 clk = ~clk;

    // Reference model: list of in-flight results, element 0 = youngest.
    typedef struct packed {
        logic              v;
        logic [REG_W-1:0]  dest;
        logic [DATA_W-1:0] data;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_cnt;

    function automatic void exp_fwd(input logic [REG_W-1:0] addr, output logic [1:0] sel,
                                    output logic [DATA_W-1:0] data);
        sel  = 2'b00;
        data = '0;
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].v && mq[i].dest == addr) begin
                sel  = 2'(i + 1);
                data = mq[i].data;
                return;
            end
        end
    endfunction

    function automatic logic exp_wb_en();
        return mq[DEPTH-1].v & ~stall;
    endfunction

    task automatic model_edge();
        ent_t              e;
        logic [1:0]        sa, sb;
        logic [DATA_W-1:0] d;
        if (reset) begin
            mq.delete();
            for (int i = 0; i < DEPTH; i++) mq.push_back('0);
            m_cnt = '0;
        end else if (!stall) begin
            exp_fwd(ra_addr, sa, d);
            exp_fwd(rb_addr, sb, d);
            if (CNT_EN && (sa != 2'b00 || sb != 2'b00)) m_cnt = m_cnt + 32'd1;
            e.v    = ex_valid & ex_wr_en & ~flush;
            e.dest = ex_dest;
            e.data = ex_result;
            mq.push_front(e);
            void'(mq.pop_back());
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid = 1'b0; ex_wr_en = 1'b0; ex_result = '0; ex_dest = '0;
        stall = 1'b0; flush = 1'b0; ra_addr = 7'd100; rb_addr = 7'd101;
    endtask

    task automatic drain();
        idle_inputs();
        for (int i = 0; i < DEPTH; i++) tick();
    endtask

    task automatic write(input logic [REG_W-1:0] dest, input logic [DATA_W-1:0] data);
        ex_valid = 1'b1; ex_wr_en = 1'b1; ex_dest = dest; ex_result = data;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        write(7'd9, 128'h55);
        ra_addr = 7'd9; rb_addr = 7'd9;
        tick();
        tick();
        reset = 1'b0;
        ex_valid = 1'b0;
        checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL reset_wb_en got %b want 0", wb_en); end
        checks++; if (wb_addr !== '0) begin errors++; $display("FAIL reset_wb_addr got %0d want 0", wb_addr); end
        checks++; if (fwd_sel_a !== 2'b00) begin errors++; $display("FAIL reset_sel_a got %b want 00", fwd_sel_a); end
        checks++; if (fwd_sel_b !== 2'b00) begin errors++; $display("FAIL reset_sel_b got %b want 00", fwd_sel_b); end
        checks++; if (fwd_count !== 32'd0) begin errors++; $display("FAIL reset_count got %0d want 0", fwd_count); end
        for (int k = 1; k <= DEPTH + 1; k++) begin
            checks++;
            if (wb_en !== 1'b0) begin errors++; $display("FAIL reset_no_capture k=%0d got %b want 0", k, wb_en); end
            tick();
        end
    endtask

    task automatic test_latency();
        idle_inputs();
        write(7'd9, 128'hDEAD);
        tick();
        ex_valid = 1'b0;
        for (int k = 1; k <= DEPTH + 2; k++) begin
            checks++;
            if (wb_en !== (k == DEPTH)) begin
                errors++; $display("FAIL latency_wb_en k=%0d got %b want %b", k, wb_en, k == DEPTH);
            end
            if (k == DEPTH) begin
                checks++;
                if (wb_addr !== 7'd9 || wb_data !== 128'hDEAD) begin
                    errors++; $display("FAIL latency_wb got %0d/%0h want 9/dead", wb_addr, wb_data);
                end
            end
            tick();
        end
    endtask

    task automatic test_priority();
        drain();
        write(7'd5, 128'h11); tick();
        write(7'd5, 128'h22); tick();
        ex_valid = 1'b0; ra_addr = 7'd5;
        #1;
        checks++;
        if (fwd_sel_a !== 2'b01 || fwd_data_a !== 128'h22) begin
            errors++; $display("FAIL prio_youngest got %b/%0h want 01/22", fwd_sel_a, fwd_data_a);
        end
        tick();
        checks++;
        if (fwd_sel_a !== 2'b10 || fwd_data_a !== 128'h22) begin
            errors++; $display("FAIL prio_after_bubble got %b/%0h want 10/22", fwd_sel_a, fwd_data_a);
        end
    endtask

    task automatic test_flush();
        drain();
        write(7'd7, 128'h33); flush = 1'b1; rb_addr = 7'd7;
        tick();
        ex_valid = 1'b0; flush = 1'b0;
        for (int k = 1; k <= DEPTH + 1; k++) begin
            checks++;
            if (fwd_sel_b !== 2'b00 || wb_en !== 1'b0) begin
                errors++; $display("FAIL flush k=%0d got sel_b %b wb_en %b want 00/0", k, fwd_sel_b, wb_en);
            end
            tick();
        end
    endtask

    task automatic test_stall();
        drain();
        write(7'd3, 128'h44); tick();
        ex_valid = 1'b0;
        for (int i = 1; i < DEPTH; i++) tick();
        stall = 1'b1; ra_addr = 7'd3;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if (wb_en !== 1'b0 || fwd_sel_a !== 2'(DEPTH) || fwd_data_a !== 128'h44) begin
                errors++; $display("FAIL stall_hold k=%0d got wb_en %b sel %b data %0h want 0/%0d/44",
                                   k, wb_en, fwd_sel_a, fwd_data_a, DEPTH);
            end
            tick();
        end
        stall = 1'b0;
        #1;
        checks++;
        if (wb_en !== 1'b1 || wb_addr !== 7'd3 || wb_data !== 128'h44) begin
            errors++; $display("FAIL stall_release got %b/%0d/%0h want 1/3/44", wb_en, wb_addr, wb_data);
        end
        tick();
        checks++;
        if (wb_en !== 1'b0) begin errors++; $display("FAIL stall_once got %b want 0", wb_en); end
    endtask

    task automatic test_fwd_count();
        logic [31:0] want;
        idle_inputs();
        reset = 1'b1; tick(); reset = 1'b0;
        write(7'd2, 128'h66); ra_addr = 7'd2;
        tick();
        for (int k = 0; k < 4; k++) tick();
        stall = 1'b1;
        tick();
        stall = 1'b0; ex_valid = 1'b0; ra_addr = 7'd100; rb_addr = 7'd101;
        want = CNT_EN ? 32'd4 : 32'd0;
        #1;
        checks++;
        if (fwd_count !== want) begin errors++; $display("FAIL fwd_count got %0d want %0d", fwd_count, want); end
    endtask

    task automatic test_random();
        logic [1:0]        sa, sb;
        logic [DATA_W-1:0] da, db;
        idle_inputs();
        reset = 1'b1; tick(); reset = 1'b0;
        for (int n = 0; n < 400; n++) begin
            reset     = ($urandom_range(0, 60) == 0);
            ex_valid  = $urandom_range(0, 3) != 0;
            ex_wr_en  = $urandom_range(0, 4) != 0;
            ex_dest   = 7'($urandom_range(0, 5));
            ex_result = {$urandom, $urandom, $urandom, $urandom};
            stall     = $urandom_range(0, 4) == 0;
            flush     = $urandom_range(0, 6) == 0;
            ra_addr   = 7'($urandom_range(0, 6));
            rb_addr   = 7'($urandom_range(0, 6));
            #1;
            exp_fwd(ra_addr, sa, da);
            exp_fwd(rb_addr, sb, db);
            checks++;
            if (fwd_sel_a !== sa || fwd_data_a !== da) begin
                errors++; $display("FAIL rand_fwd_a n=%0d got %b/%0h want %b/%0h", n, fwd_sel_a, fwd_data_a, sa, da);
            end
            checks++;
            if (fwd_sel_b !== sb || fwd_data_b !== db) begin
                errors++; $display("FAIL rand_fwd_b n=%0d got %b/%0h want %b/%0h", n, fwd_sel_b, fwd_data_b, sb, db);
            end
            checks++;
            if (wb_en !== exp_wb_en()) begin
                errors++; $display("FAIL rand_wb_en n=%0d got %b want %b", n, wb_en, exp_wb_en());
            end
            checks++;
            if (wb_addr !== mq[DEPTH-1].dest || wb_data !== mq[DEPTH-1].data) begin
                errors++; $display("FAIL rand_wb n=%0d got %0d/%0h want %0d/%0h", n, wb_addr, wb_data,
                                   mq[DEPTH-1].dest, mq[DEPTH-1].data);
            end
            checks++;
            if (fwd_count !== m_cnt) begin
                errors++; $display("FAIL rand_count n=%0d got %0d want %0d", n, fwd_count, m_cnt);
            end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mq.push_back('0);
        m_cnt = '0;
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_latency();
        test_priority();
        test_flush();
        test_stall();
        test_fwd_count();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
